mt32_gen: RTL and testbench



---
 rtl/mt32_pkg.sv | 36 +++
 rtl/mt32_if.sv | 42 ++++
 rtl/mt32_temper.sv | 24 ++
 rtl/mt32_gen.sv | 106 ++++++++++
 tb/tb_mt32_gen.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mt32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mt32_pkg
//  Description : Shared MT19937 constants, FSM encoding and index helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mt32_pkg;

    localparam int          N        = 624;
    localparam int          M        = 397;
    localparam int          AW       = 10;
    localparam logic [31:0] MATRIX_A = 32'h9908B0DF;
    localparam logic [31:0] TEMPER_B = 32'h9D2C5680;
    localparam logic [31:0] TEMPER_C = 32'hEFC60000;

    localparam int          ST_W      = 3;
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_PRIME0 = 3'd1;
    localparam logic [2:0]  ST_PRIME1 = 3'd2;
    localparam logic [2:0]  ST_RD_A   = 3'd3;
    localparam logic [2:0]  ST_RD_B   = 3'd4;
    localparam logic [2:0]  ST_CALC   = 3'd5;
    localparam logic [2:0]  ST_OUT    = 3'd6;

    // Circular successor of a state index.
    function automatic logic [AW-1:0] idx_next(input logic [AW-1:0] idx);
        return (idx == AW'(N - 1)) ? '0 : idx + AW'(1);
    endfunction

    // Index of the word M positions ahead, wrapping around the state ring.
    function automatic logic [AW-1:0] idx_far(input logic [AW-1:0] idx);
        return (idx < AW'(N - M)) ? idx + AW'(M) : idx - AW'(N - M);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mt32_if.sv
`default_nettype none
// ============================================================================
//  Module      : mt32_if
//  Description : State RAM ports and random-number stream of the generator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mt32_if;
    import mt32_pkg::*;

    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [31:0]   rnd_data;
    logic          rnd_valid;
    logic          rnd_ready;

    modport master (
        output rd_addr,
        input  rd_data,
        output wr_en,
        output wr_addr,
        output wr_data,
        output rnd_data,
        output rnd_valid,
        input  rnd_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rnd_data,
        input  rnd_valid,
        output rnd_ready
    );

endinterface
`default_nettype wire

// File: rtl/mt32_temper.sv
`default_nettype none
// ============================================================================
//  Module      : mt32_temper
//  Description : Combinational MT19937 tempering transform.
//  Revision    : 1.0 - initial release
// ============================================================================
module mt32_temper
    import mt32_pkg::*;
(
    input  wire logic [31:0] i_data,
    output logic      [31:0] o_data
);

    logic [31:0] w_s1;
    logic [31:0] w_s2;
    logic [31:0] w_s3;

    assign w_s1   = i_data ^ (i_data >> 11);
    assign w_s2   = w_s1 ^ ((w_s1 << 7) & TEMPER_B);
    assign w_s3   = w_s2 ^ ((w_s2 << 15) & TEMPER_C);
    assign o_data = w_s3 ^ (w_s3 >> 18);

endmodule
`default_nettype wire

// File: rtl/mt32_gen.sv
`default_nettype none
// ============================================================================
//  Module      : mt32_gen
//  Description : MT19937 in-place twist of the shared state RAM, tempered
//                output delivered one word per valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mt32_gen
    import mt32_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  start,
    input  wire logic  hold,
    output logic       busy,
    mt32_if.master     bus
);

    logic [ST_W-1:0] r_state;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_cur;
    logic [31:0]     r_nxt;
    logic [31:0]     r_rnd;

    logic [AW-1:0]   w_idx1;
    logic [AW-1:0]   w_idxm;
    logic [31:0]     w_y;
    logic [31:0]     w_twist;
    logic [31:0]     w_tempered;

    assign w_idx1 = idx_next(r_idx);
    assign w_idxm = idx_far(r_idx);

    // rd_data in CALC is the far word mt[i+M]; cur/nxt hold mt[i] and mt[i+1].
    assign w_y     = {r_cur[31], r_nxt[30:0]};
    assign w_twist = bus.rd_data ^ (w_y >> 1) ^ (r_nxt[0] ? MATRIX_A : 32'h0);

    mt32_temper u_temper (
        .i_data (w_twist),
        .o_data (w_tempered)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cur   <= '0;
            r_nxt   <= '0;
            r_rnd   <= '0;
        end else if (hold) begin
            r_state <= ST_IDLE;
        end else if (start) begin
            r_state <= ST_PRIME0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_PRIME0: r_state <= ST_PRIME1;
                ST_PRIME1: begin
                    r_cur   <= bus.rd_data;
                    r_state <= ST_RD_A;
                end
                ST_RD_A:   r_state <= ST_RD_B;
                ST_RD_B: begin
                    r_nxt   <= bus.rd_data;
                    r_state <= ST_CALC;
                end
                ST_CALC: begin
                    r_rnd   <= w_tempered;
                    r_state <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.rnd_ready) begin
                        r_cur   <= r_nxt;
                        r_idx   <= w_idx1;
                        r_state <= ST_RD_A;
                    end
                end
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Write strobe is masked by hold so the init stage owns the RAM port.
    always_comb begin
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        case (r_state)
            ST_RD_A: bus.rd_addr = w_idx1;
            ST_RD_B: bus.rd_addr = w_idxm;
            ST_CALC: begin
                bus.wr_en   = ~hold;
                bus.wr_addr = r_idx;
                bus.wr_data = w_twist;
            end
            default: ;
        endcase
    end

    assign bus.rnd_data  = r_rnd;
    assign bus.rnd_valid = (r_state == ST_OUT) && !hold;
    assign busy          = (r_state != ST_IDLE) && !hold;

endmodule
`default_nettype wire

// File: tb/tb_mt32_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mt32_gen
//  Description : Scoreboard bench for mt32_gen against a batch MT19937 model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mt32_gen;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic hold;
    logic busy;

    logic        init_we;
    logic [9:0]  init_addr;
    logic [31:0] init_data;
    logic [31:0] mem [0:1023];

    mt32_if bus ();

    mt32_gen dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .hold  (hold),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // State RAM: init stage writes while hold is high, generator otherwise.
    always @(posedge clk) begin
        if (hold && init_we)
            mem[init_addr] <= init_data;
        else if (bus.wr_en)
            mem[bus.wr_addr] <= bus.wr_data;
        bus.rd_data <= mem[bus.rd_addr];
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_acc    = 0;
    logic [31:0] exp_q [$];

    // Reference model: classic batch-regenerate MT19937.
    logic [31:0] mdl_mt   [0:623];
    logic [31:0] mdl_snap [0:623];
    int          mdl_idx;
    bit          mdl_snapped;

    function automatic logic [31:0] seed_step(logic [31:0] prev, int k);
        return 32'd1812433253 * (prev ^ (prev >> 30)) + k;
    endfunction

    function automatic void mdl_seed(logic [31:0] s);
        mdl_mt[0] = s;
        for (int k = 1; k < 624; k++) mdl_mt[k] = seed_step(mdl_mt[k-1], k);
        mdl_idx     = 624;
        mdl_snapped = 1'b0;
    endfunction

    function automatic logic [31:0] mdl_next();
        logic [31:0] y;
        if (mdl_idx >= 624) begin
            for (int k = 0; k < 624; k++) begin
                y = (mdl_mt[k] & 32'h80000000) | (mdl_mt[(k + 1) % 624] & 32'h7FFFFFFF);
                mdl_mt[k] = mdl_mt[(k + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
            end
            if (!mdl_snapped) begin
                for (int k = 0; k < 624; k++) mdl_snap[k] = mdl_mt[k];
                mdl_snapped = 1'b1;
            end
            mdl_idx = 0;
        end
        y = mdl_mt[mdl_idx];
        mdl_idx++;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C5680);
        y = y ^ ((y << 15) & 32'hEFC60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: bound expired, got no event expected event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fill the RAM with the seeded state, acting as the init stage.
    task automatic init_ram(input logic [31:0] s);
        logic [31:0] v;
        hold = 1'b1;
        v    = s;
        for (int k = 0; k < 624; k++) begin
            if (k > 0) v = seed_step(v, k);
            init_we   = 1'b1;
            init_addr = 10'(k);
            init_data = v;
            tick();
        end
        init_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            tick();
            t++;
        end
        if (exp_q.size() != 0) timeout(name);
    endtask

    task automatic wait_wr(input string name);
        int t = 0;
        while (!bus.wr_en && t < 20) begin
            tick();
            t++;
        end
        if (!bus.wr_en) timeout(name);
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!bus.rnd_valid && t < 20) begin
            tick();
            t++;
        end
        if (!bus.rnd_valid) timeout(name);
    endtask

    initial begin
        logic [31:0] exp2;
        logic [9:0]  stall_addr;
        int          first_wr;
        int          first_val;
        int          wr_at;
        int          bad;
        int          t;

        fork
            forever begin
                @(negedge clk);
                if (bus.rnd_valid && bus.rnd_ready) begin
                    n_acc++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got %0d expected no output", bus.rnd_data);
                    end else begin
                        chk($sformatf("rnd_data[%0d]", n_acc), bus.rnd_data, exp_q.pop_front());
                    end
                end
            end
        join_none

        reset = 1'b1; start = 1'b0; hold = 1'b0; init_we = 1'b0;
        init_addr = '0; init_data = '0; bus.rnd_ready = 1'b0;
        repeat (3) tick();
        chk("reset_busy",      {31'b0, busy},          0);
        chk("reset_rnd_valid", {31'b0, bus.rnd_valid}, 0);
        chk("reset_wr_en",     {31'b0, bus.wr_en},     0);
        chk("reset_rd_addr",   {22'b0, bus.rd_addr},   0);
        chk("reset_rnd_data",  bus.rnd_data,           0);
        reset = 1'b0;

        // Run 1: seed 5489, latency, stall, then 10000 words with random ready.
        init_ram(32'd5489);
        hold = 1'b0;
        mdl_seed(32'd5489);
        exp2 = '0;
        for (int k = 0; k < 10000; k++) begin
            exp_q.push_back(mdl_next());
            if (k == 1) exp2 = exp_q[k];
        end
        bus.rnd_ready = 1'b1;
        n_acc = 0;
        pulse_start();
        first_wr = -1; first_val = -1; wr_at = -1;
        for (int c = 1; c <= 20 && first_val < 0; c++) begin
            if (bus.wr_en && first_wr < 0) begin
                first_wr = c;
                wr_at    = int'(bus.wr_addr);
            end
            if (bus.rnd_valid) first_val = c;
            if (first_val < 0) tick();
        end
        chk("first_write_cycle", 32'(first_wr), 5);
        chk("first_write_addr",  32'(wr_at),    0);
        chk("first_valid_cycle", 32'(first_val), 6);

        t = 0;
        while (n_acc < 1 && t < 20) begin tick(); t++; end
        if (n_acc < 1) timeout("first_accept");
        bus.rnd_ready = 1'b0;
        wait_valid("stall_valid");
        stall_addr = bus.rd_addr;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (!bus.rnd_valid || bus.rnd_data !== exp2 || bus.wr_en || bus.rd_addr !== stall_addr)
                bad++;
            tick();
        end
        chk("stall_stable_cycles_bad", 32'(bad), 0);

        t = 0;
        while (n_acc < 10000 && t < 70000) begin
            bus.rnd_ready = ($urandom_range(3) != 0);
            tick();
            t++;
            if (n_acc >= 624 && mdl_snapped) begin
                bad = 0;
                for (int k = 0; k < 624; k++) if (mem[k] !== mdl_snap[k]) bad++;
                chk("ram_image_after_624_bad_words", 32'(bad), 0);
                mdl_snapped = 1'b0;
            end
        end
        chk("run1_accepted", 32'(n_acc), 10000);
        bus.rnd_ready = 1'b1;

        // Run 2: hold in the CALC of output 300, then re-seed with 1.
        init_ram(32'd5489);
        hold = 1'b0;
        mdl_seed(32'd5489);
        exp_q.delete();
        for (int k = 0; k < 299; k++) exp_q.push_back(mdl_next());
        n_acc = 0;
        pulse_start();
        t = 0;
        while (n_acc < 299 && t < 2000) begin tick(); t++; end
        if (n_acc < 299) timeout("reach_output_300");
        wait_wr("calc_of_300");
        hold = 1'b1;
        #1;
        chk("hold_busy",      {31'b0, busy},          0);
        chk("hold_rnd_valid", {31'b0, bus.rnd_valid}, 0);
        chk("hold_wr_en",     {31'b0, bus.wr_en},     0);
        init_ram(32'd1);
        hold = 1'b0;
        tick(); tick();
        chk("idle_after_hold_busy", {31'b0, busy}, 0);
        mdl_seed(32'd1);
        for (int k = 0; k < 5; k++) exp_q.push_back(mdl_next());
        pulse_start();
        wait_drain("seed1_outputs", 200);

        // Run 3: start pulsed while an output is pending.
        bus.rnd_ready = 1'b0;
        wait_valid("pending_valid");
        pulse_start();
        chk("restart_rd_addr",   {22'b0, bus.rd_addr},   0);
        chk("restart_busy",      {31'b0, busy},          1);
        chk("restart_rnd_valid", {31'b0, bus.rnd_valid}, 0);
        tick();
        init_ram(32'd5489);
        hold = 1'b0;
        mdl_seed(32'd5489);
        for (int k = 0; k < 3; k++) exp_q.push_back(mdl_next());
        bus.rnd_ready = 1'b1;
        pulse_start();
        wait_drain("restart_outputs", 200);
        bus.rnd_ready = 1'b0;

        // Reset landing in CALC.
        wait_wr("calc_before_reset");
        reset = 1'b1;
        tick();
        chk("rst_busy",      {31'b0, busy},          0);
        chk("rst_rnd_valid", {31'b0, bus.rnd_valid}, 0);
        chk("rst_wr_en",     {31'b0, bus.wr_en},     0);
        chk("rst_wr_addr",   {22'b0, bus.wr_addr},   0);
        chk("rst_wr_data",   bus.wr_data,            0);
        chk("rst_rd_addr",   {22'b0, bus.rd_addr},   0);
        chk("rst_rnd_data",  bus.rnd_data,           0);
        reset = 1'b0;
        bus.rnd_ready = 1'b1;
        repeat (8) tick();
        chk("rst_stays_idle", {31'b0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
